// File: rtl/polaris_dbus_pkg.sv
// Shared encodings and lane helpers for the CPU data-bus responder.
package polaris_dbus_pkg;

  typedef enum logic [1:0] {
    SIZ_BYTE  = 2'b00,
    SIZ_HALF  = 2'b01,
    SIZ_WORD  = 2'b10,
    SIZ_DWORD = 2'b11
  } dsiz_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dstate_e;

  function automatic logic is_misaligned(input logic [1:0] siz, input logic [2:0] off);
    logic mis;
    unique case (siz)
      SIZ_BYTE: mis = 1'b0;
      SIZ_HALF: mis = off[0];
      SIZ_WORD: mis = |off[1:0];
      default:  mis = |off;
    endcase
    return mis;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] siz, input logic [2:0] off);
    logic [7:0] lanes;
    unique case (siz)
      SIZ_BYTE: lanes = 8'h01;
      SIZ_HALF: lanes = 8'h03;
      SIZ_WORD: lanes = 8'h0F;
      default:  lanes = 8'hFF;
    endcase
    return lanes << off;
  endfunction

endpackage

// File: rtl/polaris_dmem_ram.sv
// Single-port 64-bit data RAM with byte enables; read data registered one cycle after address.
module polaris_dmem_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [7:0]           be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  output logic [63:0]          rdata_o
);

  logic [63:0] mem [2**ADDR_BITS];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 8; b++) begin
          if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/polaris_dmem_responder.sv
// Data-port bus responder: strobe/ack handshake with wait states, store lane steering
// and load extraction with sign/zero extension over a byte-enabled RAM.
module polaris_dmem_responder
  import polaris_dbus_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic        dwe_i,
  input  logic [63:0] dadr_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dsigned_i,
  input  logic [63:0] ddat_i,
  output logic [63:0] ddat_o,
  output logic        dack_o,
  output logic        misalign_o
);

  localparam int AW = ADDR_BITS + 3;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dstate_e       state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [1:0]    siz_q, siz_d;
  logic          sgn_q, sgn_d;
  logic          we_q, we_d;
  logic          mis_q, mis_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          misalign_q, misalign_d;

  logic          req;
  logic          enter_ack;
  logic [AW-1:0] cur_adr;
  logic [1:0]    cur_siz;
  logic          cur_we;
  logic          cur_mis;
  logic [63:0]   cur_wdata;
  logic [63:0]   rdata;
  logic [63:0]   field;
  logic [63:0]   ext;
  logic          unused_adr;

  assign unused_adr = ^dadr_i[63:AW];
  assign req        = dcyc_i & dstb_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    siz_d      = siz_q;
    sgn_d      = sgn_q;
    we_d       = we_q;
    mis_d      = mis_q;
    wdata_d    = wdata_q;
    misalign_d = misalign_q;
    enter_ack  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d   = dadr_i[AW-1:0];
          siz_d   = dsiz_i;
          sgn_d   = dsigned_i;
          we_d    = dwe_i;
          wdata_d = ddat_i;
          mis_d   = is_misaligned(dsiz_i, dadr_i[2:0]);
          if (mis_d) misalign_d = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the RAM is accessed on the capture edge, so it must see the live bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_adr   = dadr_i[AW-1:0];
      cur_siz   = dsiz_i;
      cur_we    = dwe_i;
      cur_wdata = ddat_i;
      cur_mis   = is_misaligned(dsiz_i, dadr_i[2:0]);
    end else begin
      cur_adr   = adr_q;
      cur_siz   = siz_q;
      cur_we    = we_q;
      cur_wdata = wdata_q;
      cur_mis   = mis_q;
    end
  end

  polaris_dmem_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk_i   (clk_i),
    .en_i    (enter_ack & ~cur_mis),
    .we_i    (cur_we),
    .be_i    (byte_mask(cur_siz, cur_adr[2:0])),
    .addr_i  (cur_adr[AW-1:3]),
    .wdata_i (cur_wdata << {cur_adr[2:0], 3'b000}),
    .rdata_o (rdata)
  );

  always_comb begin
    field = rdata >> {adr_q[2:0], 3'b000};
    unique case (siz_q)
      SIZ_BYTE: ext = {{56{sgn_q & field[7]}},  field[7:0]};
      SIZ_HALF: ext = {{48{sgn_q & field[15]}}, field[15:0]};
      SIZ_WORD: ext = {{32{sgn_q & field[31]}}, field[31:0]};
      default:  ext = field;
    endcase
    ddat_o = (state_q == ST_ACK && !we_q && !mis_q) ? ext : 64'd0;
  end

  assign dack_o     = (state_q == ST_ACK);
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      adr_q      <= '0;
      siz_q      <= '0;
      sgn_q      <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      siz_q      <= siz_d;
      sgn_q      <= sgn_d;
      we_q       <= we_d;
      mis_q      <= mis_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_polaris_dmem_responder.sv
// Scoreboard bench: three responders (0, 1 and 3 wait states) against a byte-array memory model.
module tb_polaris_dmem_responder;

  localparam int AB     = 6;
  localparam int NBYTES = 8 << AB;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dcyc_com = 1'b0;
  logic        dstb = 1'b0;
  logic        dwe = 1'b0;
  logic        dsigned = 1'b0;
  logic [63:0] dadr = '0;
  logic [63:0] ddat = '0;
  logic [1:0]  dsiz = '0;
  int          sel = 0;

  logic [63:0] rdat [3];
  logic        ack  [3];
  logic        mis  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    polaris_dmem_responder #(
      .ADDR_BITS   (AB),
      .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .dcyc_i     (dcyc_com && (sel == g)),
      .dstb_i     (dstb),
      .dwe_i      (dwe),
      .dadr_i     (dadr),
      .dsiz_i     (dsiz),
      .dsigned_i  (dsigned),
      .ddat_i     (ddat),
      .ddat_o     (rdat[g]),
      .dack_o     (ack[g]),
      .misalign_o (mis[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q [3][$];
  exp_t        e_mon;
  logic [7:0]  mem_m [3][NBYTES];
  logic        mis_m [3];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issue one request and queue the response the model predicts; returns in the cycle after ACK.
  task automatic req(input int k, input logic we, input logic [63:0] adr, input logic [1:0] siz,
                     input logic sgn, input logic [63:0] wd);
    exp_t        e;
    int          n;
    int          a;
    logic        misal;
    logic [63:0] v;
    n     = 1 << siz;
    a     = int'(adr % 64'(NBYTES));
    misal = (adr & 64'(n - 1)) != 0;
    sel = k; dwe = we; dadr = adr; dsiz = siz; dsigned = sgn; ddat = wd;
    dcyc_com = 1'b1; dstb = 1'b1;
    @(posedge clk); #1;
    e.cyc  = cyc + ws_of(k);
    e.data = '0;
    if (misal) begin
      mis_m[k] = 1'b1;
    end else if (we) begin
      for (int i = 0; i < n; i++) mem_m[k][a + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[k][a + i];
      if (sgn && n < 8 && v[8*n - 1])
        for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.data = v;
    end
    e.mis = mis_m[k];
    exp_q[k].push_back(e);
    repeat (ws_of(k) + 1) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle(input int n);
    dcyc_com = 1'b0; dstb = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ack[k]) begin
        if (exp_q[k].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack dut%0d: got ack at cycle %0d, required no ack", k, cyc);
        end else begin
          e_mon = exp_q[k].pop_front();
          check64($sformatf("ddat dut%0d", k), rdat[k], e_mon.data);
          check64($sformatf("misalign dut%0d", k), {63'd0, mis[k]}, {63'd0, e_mon.mis});
          check64($sformatf("ack_cycle dut%0d", k), 64'(cyc), 64'(e_mon.cyc));
        end
      end else begin
        check64($sformatf("idle_zero dut%0d", k), rdat[k], 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] rnd_adr;
    int          k;
    for (int j = 0; j < 3; j++) mis_m[j] = 1'b0;

    #2;
    for (int j = 0; j < 3; j++) begin
      check64($sformatf("rst_ack dut%0d", j), {63'd0, ack[j]}, 64'd0);
      check64($sformatf("rst_mis dut%0d", j), {63'd0, mis[j]}, 64'd0);
      check64($sformatf("rst_ddat dut%0d", j), rdat[j], 64'd0);
    end
    #20 rst = 1'b0;
    @(posedge clk); #1;

    for (int j = 0; j < 3; j++)
      for (int w = 0; w < (1 << AB); w++)
        req(j, 1'b1, 64'(w * 8), 2'b11, 1'b0, {$urandom, $urandom});
    bus_idle(2);

    // Directed sequences on the 1-wait-state responder
    req(1, 1'b1, 64'h10, 2'b11, 1'b0, 64'h0123456789ABCDEF); bus_idle(1);
    req(1, 1'b0, 64'h10, 2'b11, 1'b0, 64'h0);                bus_idle(1);
    req(1, 1'b1, 64'h13, 2'b00, 1'b0, 64'h80);               bus_idle(1);
    req(1, 1'b0, 64'h13, 2'b00, 1'b1, 64'h0);                bus_idle(1);
    req(1, 1'b0, 64'h13, 2'b00, 1'b0, 64'h0);                bus_idle(1);
    req(1, 1'b0, 64'h10, 2'b11, 1'b0, 64'h0);                bus_idle(1);
    req(1, 1'b1, 64'h0A, 2'b10, 1'b0, 64'hDEADBEEF);         bus_idle(1);
    req(1, 1'b0, 64'h08, 2'b11, 1'b0, 64'h0);                bus_idle(1);

    // Abort on the 3-wait-state responder: strobe drops in the second WAIT cycle
    sel = 2; dwe = 1'b1; dadr = 64'h20; dsiz = 2'b00; dsigned = 1'b0; ddat = 64'h55;
    dcyc_com = 1'b1; dstb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dstb = 1'b0;
    bus_idle(6);
    req(2, 1'b0, 64'h20, 2'b11, 1'b0, 64'h0); bus_idle(1);

    // Async reset during WAIT of a store, after the sticky flag has been set
    req(2, 1'b0, 64'h21, 2'b01, 1'b0, 64'h0); bus_idle(1);
    sel = 2; dwe = 1'b1; dadr = 64'h28; dsiz = 2'b11; ddat = 64'hA5A5_5A5A_C3C3_3C3C;
    dcyc_com = 1'b1; dstb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check64("async_rst_ack", {63'd0, ack[2]}, 64'd0);
    check64("async_rst_mis dut2", {63'd0, mis[2]}, 64'd0);
    check64("async_rst_mis dut1", {63'd0, mis[1]}, 64'd0);
    for (int j = 0; j < 3; j++) mis_m[j] = 1'b0;
    dcyc_com = 1'b0; dstb = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    req(2, 1'b0, 64'h28, 2'b11, 1'b0, 64'h0); bus_idle(1);
    req(1, 1'b0, 64'h10, 2'b11, 1'b0, 64'h0); bus_idle(1);

    // Back-to-back loads with zero wait states
    for (int i = 0; i < 4; i++) req(0, 1'b0, 64'(i * 8 + 8), 2'b11, 1'b0, 64'h0);
    bus_idle(2);

    // Randomised mix, including aliased upper address bits and misaligned accesses
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 2);
      rnd_adr = {$urandom, $urandom};
      dsiz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) rnd_adr = rnd_adr & ~64'((1 << dsiz) - 1);
      req(k, 1'($urandom_range(0, 1)), rnd_adr, dsiz, 1'($urandom_range(0, 1)),
          {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) bus_idle($urandom_range(0, 2));
    end
    bus_idle(10);

    for (int j = 0; j < 3; j++)
      check64($sformatf("drain dut%0d", j), 64'(exp_q[j].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
